// File: rtl/delay_line_capture_ctrl.sv
// Delay-line launcher and capture engine: toggles the launch pin, samples every tap for
// P_DL_LENGTH cycles, then drains the captured bits as bytes over a valid/ready stream.
module delay_line_capture_ctrl #(
   parameter int P_DL_LENGTH = 16,
   parameter int P_CHANNELS  = 1,
   parameter int P_SETTLE    = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_restore,
   input  logic [P_CHANNELS-1:0] i_dl_rx,
   output logic                  o_dl_tx,
   output logic                  o_busy,
   output logic [7:0]            o_byte_data,
   output logic                  o_byte_valid,
   input  logic                  i_byte_ready,
   output logic                  o_overrun
);
   localparam int L      = P_DL_LENGTH;
   localparam int NB     = L / 8;
   localparam int N      = P_CHANNELS * NB;
   localparam int SAMP_W = $clog2(L + 1);
   localparam int BYTE_W = $clog2(N + 1);
   localparam int SET_W  = (P_SETTLE > 0) ? $clog2(P_SETTLE + 1) : 1;
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(L - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N - 1);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'((P_SETTLE > 0) ? P_SETTLE - 1 : 0);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DRAIN} state_t;

   state_t                         r_state, w_next;
   logic [P_CHANNELS-1:0][L-1:0]   r_shreg;
   logic [SAMP_W-1:0]              r_samp_cnt;
   logic [BYTE_W-1:0]              r_byte_idx;
   logic [SET_W-1:0]               r_set_cnt;
   logic                           r_tx, r_restore, r_overrun, r_byte_valid;
   logic [7:0]                     r_byte_data;
   logic                           w_accept, w_last, w_hs;
   logic [BYTE_W-1:0]              w_nidx;
   logic [7:0]                     w_bytes [2**BYTE_W];

   // Flat byte view of all shift registers; padding entries are never selected.
   for (genvar g = 0; g < 2**BYTE_W; g++) begin : g_bytes
      if (g < N) begin : g_real
         assign w_bytes[g] = r_shreg[g / NB][8*(g % NB) +: 8];
      end else begin : g_pad
         assign w_bytes[g] = 8'h00;
      end
   end

   assign w_hs   = r_byte_valid & i_byte_ready;
   assign w_nidx = r_byte_idx + BYTE_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         IDLE:    if (i_start) begin
                     w_accept = 1'b1;
                     w_next   = (P_SETTLE > 0) ? SETTLE : CAPTURE;
                  end
         SETTLE:  if (r_set_cnt == SET_LAST) w_next = CAPTURE;
         CAPTURE: if (r_samp_cnt == SAMP_LAST) w_next = DRAIN;
         DRAIN:   if (w_hs && r_byte_idx == BYTE_LAST) begin
                     w_last = 1'b1;
                     w_next = IDLE;
                  end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shreg      <= '0;
         r_samp_cnt   <= '0;
         r_byte_idx   <= '0;
         r_set_cnt    <= '0;
         r_tx         <= 1'b1;
         r_restore    <= 1'b0;
         r_overrun    <= 1'b0;
         r_byte_valid <= 1'b0;
         r_byte_data  <= 8'h00;
      end else begin
         r_overrun <= i_start && (r_state != IDLE);
         if (w_accept) begin
            r_tx      <= ~r_tx;
            r_restore <= i_restore;
         end else if (w_last && r_restore) begin
            r_tx <= ~r_tx;
         end
         case (r_state)
            SETTLE: r_set_cnt <= (w_next != SETTLE) ? '0 : r_set_cnt + 1'b1;
            CAPTURE: begin
               for (int c = 0; c < P_CHANNELS; c++)
                  r_shreg[c] <= {r_shreg[c][L-2:0], i_dl_rx[c]};
               if (w_next != CAPTURE) begin
                  // Byte 0 must already include the sample being shifted in on this edge.
                  r_samp_cnt   <= '0;
                  r_byte_idx   <= '0;
                  r_byte_valid <= 1'b1;
                  r_byte_data  <= {r_shreg[0][6:0], i_dl_rx[0]};
               end else begin
                  r_samp_cnt <= r_samp_cnt + 1'b1;
               end
            end
            DRAIN: if (w_hs) begin
               if (w_last) begin
                  r_byte_valid <= 1'b0;
                  r_byte_idx   <= '0;
               end else begin
                  r_byte_idx  <= w_nidx;
                  r_byte_data <= w_bytes[w_nidx];
               end
            end
            default: ;
         endcase
      end
   end

   assign o_dl_tx      = r_tx;
   assign o_busy       = (r_state != IDLE);
   assign o_byte_data  = r_byte_data;
   assign o_byte_valid = r_byte_valid;
   assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_delay_line_capture_ctrl.sv
// Bench for delay_line_capture_ctrl: two instances (L=16,C=1,S=0 and L=16,C=2,S=3) checked
// every cycle against a sample-list model, plus hand-computed literal expectations.
module tb_delay_line_capture_ctrl;
   localparam int L = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       st, rs, rdy;
   logic [1:0][1:0]  rx;
   logic [1:0]       tx, busy, vld, ovr;
   logic [1:0][7:0]  dat;
   int               tests = 0, fails = 0;
   bit               chk_en = 1'b0;

   always #5 clk = ~clk;

   delay_line_capture_ctrl #(.P_DL_LENGTH(L), .P_CHANNELS(1), .P_SETTLE(0)) u_a (
      .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_restore(rs[0]), .i_dl_rx(rx[0][0]),
      .o_dl_tx(tx[0]), .o_busy(busy[0]), .o_byte_data(dat[0]), .o_byte_valid(vld[0]),
      .i_byte_ready(rdy[0]), .o_overrun(ovr[0]));

   delay_line_capture_ctrl #(.P_DL_LENGTH(L), .P_CHANNELS(2), .P_SETTLE(3)) u_b (
      .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_restore(rs[1]), .i_dl_rx(rx[1]),
      .o_dl_tx(tx[1]), .o_busy(busy[1]), .o_byte_data(dat[1]), .o_byte_valid(vld[1]),
      .i_byte_ready(rdy[1]), .o_overrun(ovr[1]));

   // Model: counts cycles since the accepted start, records each tap sample by its
   // sample number, then forms bytes directly from sample numbers.
   logic [1:0]       m_tx, m_busy, m_vld, m_ovr, m_rs;
   logic [1:0][7:0]  m_dat;
   int               m_ph [2];
   int               m_bi [2];
   bit               m_s [2][2][L+1];
   logic [7:0]       m_bytes [2][4];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int nc, ns, nb;
         nc = d + 1;
         ns = d * 3;
         nb = nc * L / 8;
         if (rst) begin
            m_tx[d] = 1'b1; m_busy[d] = 1'b0; m_vld[d] = 1'b0; m_ovr[d] = 1'b0;
            m_dat[d] = 8'h00; m_ph[d] = 0; m_bi[d] = 0;
         end else begin
            m_ovr[d] = st[d] && m_busy[d];
            if (!m_busy[d]) begin
               if (st[d]) begin
                  m_busy[d] = 1'b1; m_tx[d] = ~m_tx[d]; m_rs[d] = rs[d]; m_ph[d] = 0;
               end
            end else if (!m_vld[d]) begin
               m_ph[d]++;
               if (m_ph[d] > ns)
                  for (int c = 0; c < nc; c++) m_s[d][c][m_ph[d]-ns] = rx[d][c];
               if (m_ph[d] == ns + L) begin
                  for (int c = 0; c < nc; c++)
                     for (int k = 0; k < L/8; k++)
                        for (int b = 0; b < 8; b++)
                           m_bytes[d][c*(L/8)+k][b] = m_s[d][c][L-8*k-b];
                  m_vld[d] = 1'b1; m_bi[d] = 0; m_dat[d] = m_bytes[d][0];
               end
            end else if (rdy[d]) begin
               m_bi[d]++;
               if (m_bi[d] == nb) begin
                  m_vld[d] = 1'b0; m_busy[d] = 1'b0;
                  if (m_rs[d]) m_tx[d] = ~m_tx[d];
               end else begin
                  m_dat[d] = m_bytes[d][m_bi[d]];
               end
            end
         end
      end
   end

   task automatic cmp(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d t=%0t got %0h want %0h", nm, d, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int d = 0; d < 2; d++) begin
            cmp("m_tx", d, tx[d], m_tx[d]);
            cmp("m_busy", d, busy[d], m_busy[d]);
            cmp("m_valid", d, vld[d], m_vld[d]);
            cmp("m_overrun", d, ovr[d], m_ovr[d]);
            if (m_vld[d]) cmp("m_data", d, dat[d], m_dat[d]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int d, input int maxc);
      int n = 0;
      while (!vld[d] && n < maxc) begin tick(); n++; end
      cmp("wait_valid", d, vld[d], 1);
   endtask

   task automatic wait_idle(input int d, input int maxc);
      int n = 0;
      while (busy[d] && n < maxc) begin tick(); n++; end
      cmp("wait_idle", d, busy[d], 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bp_exp [2];
      int got;
      rst = 1'b1; st = '0; rs = '0; rdy = '0; rx = '0;
      tick(); tick();
      for (int d = 0; d < 2; d++) begin
         cmp("rst_tx", d, tx[d], 1); cmp("rst_busy", d, busy[d], 0);
         cmp("rst_valid", d, vld[d], 0); cmp("rst_data", d, dat[d], 0);
         cmp("rst_overrun", d, ovr[d], 0);
      end
      rst = 1'b0; chk_en = 1'b1;
      tick();

      // Case 1: C=1 S=0, taps 1 for the first 4 samples, restore on.
      rdy[0] = 1'b1; rs[0] = 1'b1; st[0] = 1'b1; rx[0] = 2'b01;
      tick(); st[0] = 1'b0;
      cmp("c1_tx_launch", 0, tx[0], 0);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         rx[0][0] = (cyc <= 4);
         if (cyc == 16) cmp("c1_valid16", 0, vld[0], 0);
         if (cyc == 17) begin cmp("c1_valid17", 0, vld[0], 1); cmp("c1_byte0", 0, dat[0], 8'h00); end
         if (cyc == 18) begin cmp("c1_valid18", 0, vld[0], 1); cmp("c1_byte1", 0, dat[0], 8'hF0); end
         if (cyc == 19) begin cmp("c1_tx_restore", 0, tx[0], 1); cmp("c1_busy19", 0, busy[0], 0); end
         tick();
      end

      // Case 2: C=2 S=3, ch0=1 ch1=0, no restore.
      rdy[1] = 1'b1; rs[1] = 1'b0; rx[1] = 2'b01; st[1] = 1'b1;
      tick(); st[1] = 1'b0;
      for (int cyc = 1; cyc <= 24; cyc++) begin
         if (cyc == 19) cmp("c2_valid19", 1, vld[1], 0);
         if (cyc == 20) begin cmp("c2_valid20", 1, vld[1], 1); cmp("c2_byte0", 1, dat[1], 8'hFF); end
         if (cyc == 21) cmp("c2_byte1", 1, dat[1], 8'hFF);
         if (cyc == 22) cmp("c2_byte2", 1, dat[1], 8'h00);
         if (cyc == 23) cmp("c2_byte3", 1, dat[1], 8'h00);
         if (cyc == 24) begin cmp("c2_tx_held", 1, tx[1], 0); cmp("c2_busy24", 1, busy[1], 0); end
         tick();
      end
      st[1] = 1'b1; tick(); st[1] = 1'b0;
      cmp("c2_tx_second", 1, tx[1], 1);
      wait_idle(1, 60);

      // Case 3: backpressure; taps high on samples 3,6,9,12,15 -> bytes 0x92, 0x24.
      rdy[0] = 1'b0; rs[0] = 1'b0; st[0] = 1'b1;
      tick(); st[0] = 1'b0;
      for (int cyc = 1; cyc <= 16; cyc++) begin rx[0][0] = (cyc % 3 == 0); tick(); end
      rx[0][0] = 1'b0;
      bp_exp[0] = 8'h92; bp_exp[1] = 8'h24;
      for (int i = 0; i < 5; i++) begin
         cmp("bp_hold_valid", 0, vld[0], 1); cmp("bp_hold_data", 0, dat[0], 8'h92);
         tick();
      end
      got = 0;
      for (int i = 0; i < 12 && busy[0]; i++) begin
         rdy[0] = (i % 2 == 0);
         if (vld[0] && rdy[0]) begin
            cmp("bp_order", 0, dat[0], (got < 2) ? bp_exp[got] : 8'hXX);
            got++;
         end
         tick();
      end
      cmp("bp_count", 0, got, 2);

      // Case 4: start during CAPTURE and on the last handshake -> overrun pulses.
      rdy[0] = 1'b1; rs[0] = 1'b1; rx[0] = 2'b01; st[0] = 1'b1;
      tick(); st[0] = 1'b0;
      for (int cyc = 1; cyc <= 21; cyc++) begin
         st[0] = (cyc == 5 || cyc == 18);
         if (cyc == 6) cmp("ov_cap_pulse", 0, ovr[0], 1);
         if (cyc == 7) cmp("ov_cap_clear", 0, ovr[0], 0);
         if (cyc == 17) cmp("ov_byte0", 0, dat[0], 8'hFF);
         if (cyc == 18) cmp("ov_byte1", 0, dat[0], 8'hFF);
         if (cyc == 19) begin
            cmp("ov_last_pulse", 0, ovr[0], 1); cmp("ov_busy19", 0, busy[0], 0);
            cmp("ov_tx19", 0, tx[0], 0);
         end
         if (cyc == 20) begin cmp("ov_clear20", 0, ovr[0], 0); cmp("ov_busy20", 0, busy[0], 0); end
         tick();
      end
      st[0] = 1'b0;

      // Case 5: reset while a byte is pending, then a fresh capture.
      rdy[0] = 1'b0; rs[0] = 1'b0; st[0] = 1'b1;
      tick(); st[0] = 1'b0;
      wait_valid(0, 40);
      rst = 1'b1; tick(); rst = 1'b0;
      cmp("rd_tx", 0, tx[0], 1); cmp("rd_valid", 0, vld[0], 0); cmp("rd_busy", 0, busy[0], 0);
      rdy[0] = 1'b1; rx[0] = 2'b01; st[0] = 1'b1;
      tick(); st[0] = 1'b0;
      cmp("rd_tx_launch", 0, tx[0], 0);
      wait_valid(0, 40);
      cmp("rd_fresh_byte0", 0, dat[0], 8'hFF);
      wait_idle(0, 20);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
